// File: rtl/rv_trap_ctrl.sv
// rtl/rv_trap_ctrl.sv - M-mode trap controller: irq/exception priority, trap CSRs, pipeline redirect
// Optional feature macro RV_TRAP_VECTOR_EN: writable mtvec mode with vectored interrupt targets.
module rv_trap_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              NUM_PLAT_IRQ = 4,
  parameter logic [XLEN-1:0] MTVEC_RST    = 'h0000_0100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             instr_i,
  input  logic [XLEN-1:0]         mem_addr_i,
  input  logic                    access_fault_i,
  input  logic                    instr_illegal_i,
  input  logic                    ecall_i,
  input  logic                    ebreak_i,
  input  logic                    misaligned_i,
  input  logic                    mem_store_i,
  input  logic                    mret_i,
  input  logic                    soft_irq_i,
  input  logic                    timer_irq_i,
  input  logic                    ext_irq_i,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq_i,
  input  logic                    csr_we_i,
  input  logic [11:0]             csr_addr_i,
  input  logic [XLEN-1:0]         csr_wdata_i,
  output logic [XLEN-1:0]         csr_rdata_o,
  output logic                    redirect_o,
  output logic [XLEN-1:0]         redirect_pc_o,
  output logic                    irq_pending_o
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  typedef enum logic {S_RUN, S_REDIR} state_t;

  state_t          r_state;
  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mscratch;

  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_mie_mask;
  logic [XLEN-1:0] w_pend;
  logic [XLEN-1:0] w_mstatus;
  logic            w_irq;
  logic [4:0]      w_irq_cause;
  logic            w_exc;
  logic [4:0]      w_exc_cause;
  logic [XLEN-1:0] w_exc_tval;
  logic [4:0]      w_cause;
  logic            w_take;
  logic            w_trap;
  logic            w_mret;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_pc;
  logic [XLEN-1:0] w_mtvec_wr;

  always_comb begin
    w_mip         = '0;
    w_mie_mask    = '0;
    w_mip[3]      = soft_irq_i;
    w_mip[7]      = timer_irq_i;
    w_mip[11]     = ext_irq_i;
    w_mie_mask[3]  = 1'b1;
    w_mie_mask[7]  = 1'b1;
    w_mie_mask[11] = 1'b1;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      w_mip[16+i]      = plat_irq_i[i];
      w_mie_mask[16+i] = 1'b1;
    end
  end

  assign w_pend        = w_mip & r_mie;
  assign irq_pending_o = |w_pend;
  assign w_irq         = irq_pending_o & r_mstatus_mie;

  // Later assignments override earlier ones, so the lowest plat index and then MEI win.
  always_comb begin
    w_irq_cause = 5'd0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (w_pend[16+i]) w_irq_cause = 5'(16 + i);
    end
    if (w_pend[7])  w_irq_cause = 5'd7;
    if (w_pend[3])  w_irq_cause = 5'd3;
    if (w_pend[11]) w_irq_cause = 5'd11;
  end

  assign w_exc = access_fault_i | instr_illegal_i | ecall_i | ebreak_i | misaligned_i;

  always_comb begin
    w_exc_cause = 5'd0;
    w_exc_tval  = '0;
    if (access_fault_i) begin
      w_exc_cause = 5'd1;
      w_exc_tval  = pc_i;
    end else if (instr_illegal_i) begin
      w_exc_cause = 5'd2;
      w_exc_tval  = XLEN'(instr_i);
    end else if (ecall_i) begin
      w_exc_cause = 5'd11;
    end else if (ebreak_i) begin
      w_exc_cause = 5'd3;
      w_exc_tval  = pc_i;
    end else if (misaligned_i) begin
      w_exc_cause = mem_store_i ? 5'd6 : 5'd4;
      w_exc_tval  = mem_addr_i;
    end
  end

  assign w_cause = w_irq ? w_irq_cause : w_exc_cause;
  assign w_take  = (r_state == S_RUN) && instr_valid_i;
  assign w_trap  = w_take && (w_irq || w_exc);
  assign w_mret  = w_take && mret_i && !w_irq && !w_exc;
  assign w_base  = {r_mtvec[XLEN-1:2], 2'b00};

`ifdef RV_TRAP_VECTOR_EN
  assign w_trap_pc  = (w_irq && r_mtvec[1:0] == 2'b01) ? w_base + (XLEN'(w_irq_cause) << 2) : w_base;
  assign w_mtvec_wr = {csr_wdata_i[XLEN-1:2], (csr_wdata_i[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
  assign w_trap_pc  = w_base;
  assign w_mtvec_wr = {csr_wdata_i[XLEN-1:2], 2'b00};
`endif

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[3]     = r_mstatus_mie;
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS:  csr_rdata_o = w_mstatus;
      CSR_MIE:      csr_rdata_o = r_mie;
      CSR_MTVEC:    csr_rdata_o = r_mtvec;
      CSR_MSCRATCH: csr_rdata_o = r_mscratch;
      CSR_MEPC:     csr_rdata_o = r_mepc;
      CSR_MCAUSE:   csr_rdata_o = r_mcause;
      CSR_MTVAL:    csr_rdata_o = r_mtval;
      CSR_MIP:      csr_rdata_o = w_mip;
      default:      csr_rdata_o = '0;
    endcase
  end

  // CSR writes are issued first so trap/MRET assignments below override them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= MTVEC_RST;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mscratch     <= '0;
      redirect_o     <= 1'b0;
      redirect_pc_o  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          redirect_o <= 1'b0;
          if (csr_we_i) begin
            case (csr_addr_i)
              CSR_MSTATUS: begin
                r_mstatus_mie  <= csr_wdata_i[3];
                r_mstatus_mpie <= csr_wdata_i[7];
              end
              CSR_MIE:      r_mie      <= csr_wdata_i & w_mie_mask;
              CSR_MTVEC:    r_mtvec    <= w_mtvec_wr;
              CSR_MSCRATCH: r_mscratch <= csr_wdata_i;
              CSR_MEPC:     r_mepc     <= {csr_wdata_i[XLEN-1:2], 2'b00};
              CSR_MCAUSE:   r_mcause   <= csr_wdata_i;
              CSR_MTVAL:    r_mtval    <= csr_wdata_i;
              default: ;
            endcase
          end
          if (w_trap) begin
            r_mepc         <= pc_i;
            r_mcause       <= {w_irq, {(XLEN-6){1'b0}}, w_cause};
            r_mtval        <= w_irq ? '0 : w_exc_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            redirect_o     <= 1'b1;
            redirect_pc_o  <= w_trap_pc;
            r_state        <= S_REDIR;
          end else if (w_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
            redirect_o     <= 1'b1;
            redirect_pc_o  <= r_mepc;
            r_state        <= S_REDIR;
          end
        end
        S_REDIR: begin
          redirect_o <= 1'b0;
          r_state    <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
